cargador_texto: RTL and testbench

//   Writer side of the data-RAM text region that the 7-segment data decoder reads.
//   - Accepts a stream of 8-bit character codes over a valid/ready handshake.
//   - Stores each character as one 32-bit word ({24'b0,char}) in the data RAM.
//   - Addresses run from BASE_ADDR in steps of ADDR_STEP.
//   - On commit, writes the TERMINATOR word, so the reader sees a complete,

---
 rtl/cargador_texto.sv | 147 ++++++++++++++
 tb/tb_cargador_texto.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cargador_texto.sv
// cargador_texto: writes a stream of characters into the data-RAM text region
// as 32-bit words, starting at BASE_ADDR and stepping by ADDR_STEP. On commit
// it appends the TERMINATOR word so the reader always finds a terminated string.
// Optional build macro: ECHO_7SEG_EN adds a 7-segment echo of the last character.
module cargador_texto #(
    parameter int unsigned BASE_ADDR  = 16,
    parameter int unsigned ADDR_STEP  = 4,
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned MAX_CHARS  = 16,
    parameter logic [7:0]  TERMINATOR = 8'h26,
    localparam int unsigned CNT_W     = $clog2(MAX_CHARS + 1)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              start,
    input  logic              char_valid,
    input  logic [7:0]        char_data,
    input  logic              commit,
    output logic              char_ready,
    output logic [ADDR_W-1:0] addressForRam,
    output logic [31:0]       wdataForRam,
    output logic              weForRam,
    output logic [CNT_W-1:0]  char_count,
    output logic              done,
    output logic              overflow
`ifdef ECHO_7SEG_EN
    ,
    output logic [6:0]        segments
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WR,
        TERM,
        DONE
    } state_t;

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(ADDR_STEP);
    localparam logic [CNT_W-1:0]  FULL_C = CNT_W'(MAX_CHARS);

    state_t            state, state_nx;
    logic              full;
    logic              accept;
    logic              term_wr;
    logic              ovf_set;
    logic [ADDR_W-1:0] slot_addr;

    // Current character slot; the terminator shares the same formula.
    assign full      = (char_count == FULL_C);
    assign slot_addr = BASE_A + STEP_A * ADDR_W'(char_count);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Next state and handshake decode; start overrides everything else
    always_comb begin
        state_nx   = state;
        char_ready = 1'b0;
        accept     = 1'b0;
        term_wr    = 1'b0;
        ovf_set    = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = LOAD;
            end
            LOAD: begin
                char_ready = !commit && !full;
                if (start) begin
                    state_nx = LOAD;
                end else if (commit) begin
                    term_wr  = 1'b1;
                    state_nx = TERM;
                end else if (char_valid && !full) begin
                    accept   = 1'b1;
                    state_nx = WR;
                end else if (char_valid) begin
                    ovf_set  = 1'b1;
                end
            end
            WR:   state_nx = LOAD;
            TERM: state_nx = start ? LOAD : DONE;
            DONE: begin
                if (start) state_nx = LOAD;
            end
            default: state_nx = IDLE;
        endcase
    end

    // RAM write port, counter and status flags; writes are launched at the
    // accepting edge so the enable is high for exactly the WR/TERM cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            weForRam      <= 1'b0;
            addressForRam <= BASE_A;
            wdataForRam   <= 32'h0;
            char_count    <= '0;
            done          <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            weForRam <= 1'b0;
            if (start) begin
                char_count <= '0;
                overflow   <= 1'b0;
                done       <= 1'b0;
            end else begin
                if (accept) begin
                    weForRam      <= 1'b1;
                    addressForRam <= slot_addr;
                    wdataForRam   <= {24'h0, char_data};
                    char_count    <= char_count + CNT_W'(1);
                end
                if (term_wr) begin
                    weForRam      <= 1'b1;
                    addressForRam <= slot_addr;
                    wdataForRam   <= {24'h0, TERMINATOR};
                end
                if (ovf_set)       overflow <= 1'b1;
                if (state == TERM) done     <= 1'b1;
            end
        end
    end

`ifdef ECHO_7SEG_EN
    // Echo of the last stored character on a gfedcba active-low display
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            segments <= 7'b1000000;
        end else if (start) begin
            segments <= 7'b1000000;
        end else if (accept) begin
            case (char_data)
                8'h48:   segments <= 7'b0001001;
                8'h4F:   segments <= 7'b1000000;
                8'h03:   segments <= 7'b0110000;
                default: segments <= 7'b1000000;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_cargador_texto.sv
// Testbench for cargador_texto: directed scenarios plus random strings, with
// RAM writes captured and compared against a list-based reference model.
// Build with ECHO_7SEG_EN defined to also exercise the segment echo.
module tb_cargador_texto;

    localparam int BASE = 16;
    localparam int STEP = 4;
    localparam int MAXC = 16;
    localparam logic [7:0] TERMC = 8'h26;

    logic        clock;
    logic        reset_n;
    logic        start;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        commit;
    logic        char_ready;
    logic [7:0]  addressForRam;
    logic [31:0] wdataForRam;
    logic        weForRam;
    logic [4:0]  char_count;
    logic        done;
    logic        overflow;
`ifdef ECHO_7SEG_EN
    logic [6:0]  segments;
`endif

    int n_chk;
    int n_fail;

    logic [39:0] obs_q[$];
    logic [39:0] exp_q[$];
    logic [7:0]  model_chars[$];

    cargador_texto dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .start         (start),
        .char_valid    (char_valid),
        .char_data     (char_data),
        .commit        (commit),
        .char_ready    (char_ready),
        .addressForRam (addressForRam),
        .wdataForRam   (wdataForRam),
        .weForRam      (weForRam),
        .char_count    (char_count),
        .done          (done),
        .overflow      (overflow)
`ifdef ECHO_7SEG_EN
        ,
        .segments      (segments)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Capture every RAM write away from the active edge
    always @(negedge clock) begin
        if (reset_n && weForRam) obs_q.push_back({addressForRam, wdataForRam});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        obs_q.delete();
        model_chars.delete();
    endtask

    // Present one character, wait for acceptance, then let the WR cycle pass
    task automatic send(input logic [7:0] c);
        int k;
        char_valid = 1'b1;
        char_data  = c;
        k = 0;
        @(negedge clock);
        while (!char_ready && k < 10) begin
            @(negedge clock);
            k++;
        end
        if (!char_ready) begin
            chk("ready_timeout", {63'h0, char_ready}, 64'h1);
            char_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            char_valid = 1'b0;
            chk("we_pulse_hi", {63'h0, weForRam}, 64'h1);
            model_chars.push_back(c);
            tick();
            chk("we_pulse_lo", {63'h0, weForRam}, 64'h0);
        end
    endtask

    // Present a character while full: must be refused and flag overflow
    task automatic send_full(input logic [7:0] c);
        char_valid = 1'b1;
        char_data  = c;
        @(negedge clock);
        chk("ready_full", {63'h0, char_ready}, 64'h0);
        @(posedge clock);
        #1;
        char_valid = 1'b0;
        chk("ovf_set", {63'h0, overflow}, 64'h1);
    endtask

    task automatic do_commit(input logic with_char);
        commit     = 1'b1;
        char_valid = with_char;
        char_data  = 8'h41;
        tick();
        commit     = 1'b0;
        char_valid = 1'b0;
        tick();
        tick();
    endtask

    // Reference: each stored char at BASE+STEP*i, terminator right after
    task automatic build_expect();
        int n;
        exp_q.delete();
        n = model_chars.size();
        for (int i = 0; i < n; i++)
            exp_q.push_back({8'(BASE + STEP * i), 24'h0, model_chars[i]});
        exp_q.push_back({8'(BASE + STEP * n), 24'h0, TERMC});
    endtask

    task automatic check_writes(input string tag);
        int n;
        build_expect();
        chk({tag, "_nwr"}, 64'(obs_q.size()), 64'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_wr"}, 64'(obs_q[i]), 64'(exp_q[i]));
        chk({tag, "_done"},  {63'h0, done}, 64'h1);
        chk({tag, "_count"}, 64'(char_count), 64'(model_chars.size()));
        chk({tag, "_rdy"},   {63'h0, char_ready}, 64'h0);
        obs_q.delete();
    endtask

    task automatic run_random();
        int n;
        int ovf_tries;
        logic coll;
        do_start();
        n = $urandom_range(0, MAXC + 3);
        ovf_tries = 0;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 2)) tick();
            if (model_chars.size() < MAXC) send(8'($urandom));
            else begin
                send_full(8'($urandom));
                ovf_tries++;
            end
        end
        chk("rnd_ovf", {63'h0, overflow}, {63'h0, (ovf_tries > 0)});
        coll = ($urandom_range(0, 3) == 0);
        do_commit(coll);
        check_writes("rnd");
    endtask

    initial begin
        n_chk      = 0;
        n_fail     = 0;
        reset_n    = 1'b0;
        start      = 1'b0;
        char_valid = 1'b0;
        char_data  = 8'h0;
        commit     = 1'b0;
        #12;
        chk("rst_we",    {63'h0, weForRam}, 64'h0);
        chk("rst_addr",  64'(addressForRam), 64'(BASE));
        chk("rst_wdata", 64'(wdataForRam), 64'h0);
        chk("rst_count", 64'(char_count), 64'h0);
        chk("rst_done",  {63'h0, done}, 64'h0);
        chk("rst_ovf",   {63'h0, overflow}, 64'h0);
        chk("rst_rdy",   {63'h0, char_ready}, 64'h0);
`ifdef ECHO_7SEG_EN
        chk("rst_seg",   64'(segments), 64'h40);
`endif
        reset_n = 1'b1;
        tick();
        chk("idle_rdy", {63'h0, char_ready}, 64'h0);

        // "HO" then commit
        do_start();
        chk("load_rdy", {63'h0, char_ready}, 64'h1);
        send(8'h48);
        send(8'h4F);
        do_commit(1'b0);
        check_writes("ho");

        // Fill completely, one extra char, commit
        do_start();
        for (int i = 0; i < MAXC; i++) send(8'(8'h30 + i));
        send_full(8'h5A);
        chk("full_count", 64'(char_count), 64'(MAXC));
        do_commit(1'b0);
        check_writes("full");
        chk("full_ovf_hold", {63'h0, overflow}, 64'h1);

        // Commit and char_valid together: commit wins
        do_start();
        chk("start_clr_ovf", {63'h0, overflow}, 64'h0);
        chk("start_clr_done", {63'h0, done}, 64'h0);
        send(8'h31);
        do_commit(1'b1);
        check_writes("coll");

        // Empty string
        do_start();
        do_commit(1'b0);
        check_writes("empty");

        // Restart after three chars
        do_start();
        send(8'h01);
        send(8'h02);
        send(8'h03);
        do_start();
        chk("restart_count", 64'(char_count), 64'h0);
        chk("restart_ovf", {63'h0, overflow}, 64'h0);
        send(8'h4F);
        do_commit(1'b0);
        check_writes("restart");

        // Reset during a write cycle
        do_start();
        send(8'h55);
        char_valid = 1'b1;
        char_data  = 8'h66;
        @(negedge clock);
        @(posedge clock);
        #1;
        char_valid = 1'b0;
        chk("mid_we_hi", {63'h0, weForRam}, 64'h1);
        reset_n = 1'b0;
        #1;
        chk("mid_we",   {63'h0, weForRam}, 64'h0);
        chk("mid_addr", 64'(addressForRam), 64'(BASE));
        chk("mid_done", {63'h0, done}, 64'h0);
        chk("mid_ovf",  {63'h0, overflow}, 64'h0);
        chk("mid_rdy",  {63'h0, char_ready}, 64'h0);
        #10;
        reset_n = 1'b1;
        tick();
        tick();
        chk("mid_idle_we", {63'h0, weForRam}, 64'h0);

`ifdef ECHO_7SEG_EN
        do_start();
        send(8'h48);
        chk("seg_h", 64'(segments), 64'h09);
        send(8'h03);
        chk("seg_3", 64'(segments), 64'h30);
        send(8'h4F);
        chk("seg_o", 64'(segments), 64'h40);
        send(8'h48);
        do_start();
        chk("seg_start", 64'(segments), 64'h40);
`endif

        for (int r = 0; r < 25; r++) run_random();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
